// File: rtl/shift_pkg.sv
// Shared shift types used by the barrel shifter and its round-robin front end.
package shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    PASS = 2'b10,
    SRA  = 2'b11
  } shift_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amount;
    shift_sel_e        sel;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA or pass-through.
module barrel_shifter
  import shift_pkg::*;
(
  input  shift_req_t        req_i,
  output logic [DATA_W-1:0] result_o
);

  // Select the shift flavour; pass-through and amount 0 leave data untouched.
  always_comb begin
    result_o = req_i.data;
    case (req_i.sel)
      SLL:     result_o = req_i.data << req_i.amount;
      SRL:     result_o = req_i.data >> req_i.amount;
      SRA:     result_o = DATA_W'($signed(req_i.data) >>> req_i.amount);
      default: result_o = req_i.data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NUM_REQ requesters,
// with a single registered, tagged response slot.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  i_req_amount,
  input  logic [NUM_REQ*SEL_W-1:0]  i_req_sel,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [ID_W-1:0]           o_resp_id,
  output logic [DATA_W-1:0]         o_resp_result
);

  localparam int unsigned REQ_BITS = $bits(shift_req_t);

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_result_q, resp_result_d;

  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;
  logic                slot_free;
  logic                accept;
  logic [REQ_BITS-1:0] mux_bits;
  shift_req_t          shift_req;
  logic [DATA_W-1:0]   shift_result;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!grant_any && i_req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    grant_oh[grant_id] = grant_any;
  end

  // One-hot operand mux feeding the shared shifter.
  always_comb begin
    mux_bits = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_oh[j]) begin
        mux_bits = mux_bits | {i_req_data[j*DATA_W +: DATA_W],
                               i_req_amount[j*AMT_W +: AMT_W],
                               i_req_sel[j*SEL_W +: SEL_W]};
      end
    end
  end

  assign shift_req = shift_req_t'(mux_bits);

  barrel_shifter u_shifter (
    .req_i    (shift_req),
    .result_o (shift_result)
  );

  assign slot_free   = !resp_valid_q || i_resp_ready;
  assign accept      = slot_free && grant_any && !i_reset;
  assign o_req_ready = (slot_free && !i_reset) ? grant_oh : '0;

  // Next state: accept loads the slot (replacing a draining one), drain empties it.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = grant_id;
      resp_result_d = shift_result;
      rr_ptr_d      = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end else if (resp_valid_q && i_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
    end
  end

  assign o_resp_valid  = resp_valid_q;
  assign o_resp_id     = resp_id_q;
  assign o_resp_result = resp_result_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter with two requesters.
module tb_shift_arbiter;

  localparam int N = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_data;
  logic [N*5-1:0]  req_amount;
  logic [N*2-1:0]  req_sel;
  logic          resp_valid;
  logic          resp_ready;
  logic [0:0]    resp_id;
  logic [31:0]   resp_result;

  shift_arbiter #(.NUM_REQ(N)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_data    (req_data),
    .i_req_amount  (req_amount),
    .i_req_sel     (req_sel),
    .o_resp_valid  (resp_valid),
    .i_resp_ready  (resp_ready),
    .o_resp_id     (resp_id),
    .o_resp_result (resp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_res[N];
  int          m_rr;
  bit          m_valid;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] s);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) begin
      case (s)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b11:   r = {r[31], r[31:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] s, input logic [31:0] e);
    req_valid[i]        = v;
    req_data[i*32 +: 32] = d;
    req_amount[i*5 +: 5] = a;
    req_sel[i*2 +: 2]    = s;
    exp_res[i]          = e;
  endtask

  // One clock: predict grant, check ready/valid, push expected response, advance model.
  task automatic step();
    int          g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    exp_rdy = '0;
    if (!rst && (!m_valid || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!rst) chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    if (rst) sb.delete();
    else if (g >= 0) sb.push_back('{id: 32'(g), res: exp_res[g]});
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_rr    = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_rr    = (g + 1) % N;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: every consumed response must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got id %0d result %h expected no response", resp_id, resp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), e.id);
        chk("resp_result", resp_result, e.res);
      end
    end
  end

  logic [31:0] d_tab[5];
  logic [4:0]  a_tab[5];
  logic [1:0]  s_tab[5];
  logic [31:0] e_tab[5];

  initial begin
    d_tab = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
    a_tab = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd7};
    s_tab = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
    e_tab = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h0000_0000, 32'h1234_5678};

    rst = 1'b1;
    resp_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_amount = '0;
    req_sel = '0;
    m_valid = 1'b0;
    m_rr = 0;
    step();
    step();
    rst = 1'b0;
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_id", 32'(resp_id), 32'd0);
    chk("reset_result", resp_result, 32'h0);

    // Single requester, back to back
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, d_tab[i], a_tab[i], s_tab[i], e_tab[i]);
      step();
    end
    req_valid = '0;
    step();

    // Contention after reset: ids 0,1,0,1 with no bubbles
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002);
    set_req(1, 1'b1, 32'h0000_0100, 5'd8, 2'b01, 32'h0000_0001);
    for (int i = 0; i < 4; i++) step();
    req_valid = '0;
    step();

    // Backpressure: held response frozen, then drain+accept in the same cycle
    set_req(0, 1'b1, 32'hF000_0000, 5'd8, 2'b11, 32'hFFF0_0000);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h0000_00FF, 5'd4, 2'b00, 32'h0000_0FF0);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_result", resp_result, 32'hFFF0_0000);
      chk("stall_id", 32'(resp_id), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("drain_accept_valid", 32'(resp_valid), 32'd1);
    req_valid = '0;
    step();

    // Pointer hold across idle cycles
    set_req(1, 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) step();
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd3, 2'b10, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 32'h8000_0001, 5'd0, 2'b11, 32'h8000_0001);
    step();
    step();
    req_valid = '0;
    step();

    // Reset while a response is stalled and both request
    set_req(0, 1'b1, 32'h0000_000A, 5'd2, 2'b00, 32'h0000_0028);
    step();
    resp_ready = 1'b0;
    set_req(1, 1'b1, 32'h0000_0040, 5'd6, 2'b01, 32'h0000_0001);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_mid_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    step();

    // Random soak
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < N; r++) begin
        logic [31:0] d;
        logic [4:0]  a;
        logic [1:0]  s;
        d = $urandom;
        a = 5'($urandom_range(0, 31));
        s = 2'($urandom_range(0, 3));
        set_req(r, 1'($urandom_range(0, 1)), d, a, s, ref_shift(d, a, s));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
